// File: rtl/time_set_ctrl_if.sv
// Bundle between the set-time controller, the clock counter block and the
// display encoder: running time in, load strobe/hold/display values out.
interface time_set_ctrl_if;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic       hold;
  logic [1:0] setting;
  logic [4:0] disp_hours;
  logic [5:0] disp_minutes;
  logic       blink;

  modport master (
    input  cur_hours, cur_minutes,
    output load, load_hours, load_minutes, hold, setting,
           disp_hours, disp_minutes, blink
  );

  modport slave (
    output cur_hours, cur_minutes,
    input  load, load_hours, load_minutes, hold, setting,
           disp_hours, disp_minutes, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// Set-time controller: debounces MODE/INC, auto-repeats INC, walks
// RUN -> SET_H -> SET_M -> RUN and strobes the edited time into the clock.
module time_set_ctrl #(
  parameter int DEBOUNCE_TICKS = 5,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10,
  parameter int BLINK_HALF     = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  time_set_ctrl_if.master  bus
);

  localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  localparam int BLK_W = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  // Index 0 is MODE, index 1 is INC
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       level;
  logic [1:0]       level_d;
  logic [DEB_W-1:0] deb_cnt [2];
  logic [1:0]       press;

  logic [REP_W-1:0] rep_cnt;
  logic             rep_fire;
  logic             mode_evt;
  logic             inc_evt;

  state_t           state;
  state_t           next_state;

  logic [4:0]       edit_h;
  logic [5:0]       edit_m;
  logic             load_q;
  logic [4:0]       load_hours_q;
  logic [5:0]       load_minutes_q;

  logic             blink_q;
  logic [BLK_W-1:0] blink_cnt;

  // Two-flop synchronizers bring the raw buttons into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_inc, btn_mode};
      sync2 <= sync1;
    end
  end

  // Debounced level flips only after the synchronized input disagrees for DEBOUNCE_TICKS cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      level_d <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != level[i]) begin
          if (deb_cnt[i] == DEB_W'(DEBOUNCE_TICKS - 1)) begin
            level[i]   <= ~level[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign press    = level & ~level_d;
  assign rep_fire = level[1] && (rep_cnt == REP_W'(REPEAT_DELAY));
  assign mode_evt = press[0];
  assign inc_evt  = press[1] | rep_fire;

  // Held counter measures cycles since the INC press; after the first repeat it
  // is wound back so the next repeat lands REPEAT_RATE cycles later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt <= '0;
    end else if (!level[1]) begin
      rep_cnt <= '0;
    end else if (rep_fire) begin
      rep_cnt <= REP_W'(REPEAT_DELAY - REPEAT_RATE + 1);
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= next_state;
  end

  // Next-state logic: only MODE moves the FSM
  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (mode_evt) next_state = SET_H;
      SET_H:   if (mode_evt) next_state = SET_M;
      SET_M:   if (mode_evt) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  // Edit fields and the load strobe; MODE takes priority over a coincident INC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edit_h         <= '0;
      edit_m         <= '0;
      load_q         <= 1'b0;
      load_hours_q   <= '0;
      load_minutes_q <= '0;
    end else begin
      load_q <= 1'b0;
      case (state)
        RUN: begin
          if (mode_evt) begin
            edit_h <= bus.cur_hours;
            edit_m <= bus.cur_minutes;
          end
        end
        SET_H: begin
          if (!mode_evt && inc_evt)
            edit_h <= (edit_h >= 5'd23) ? 5'd0 : edit_h + 5'd1;
        end
        SET_M: begin
          if (mode_evt) begin
            load_q         <= 1'b1;
            load_hours_q   <= edit_h;
            load_minutes_q <= edit_m;
          end else if (inc_evt) begin
            edit_m <= (edit_m >= 6'd59) ? 6'd0 : edit_m + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Blink phase restarts high on entry to each set state and toggles every BLINK_HALF cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q   <= 1'b1;
      blink_cnt <= '0;
    end else if (next_state != state && next_state != RUN) begin
      blink_q   <= 1'b1;
      blink_cnt <= '0;
    end else if (state != RUN) begin
      if (blink_cnt == BLK_W'(BLINK_HALF - 1)) begin
        blink_q   <= ~blink_q;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_q   <= 1'b1;
      blink_cnt <= '0;
    end
  end

  // Outputs decoded from state; hold drops in the same cycle load rises
  always_comb begin
    bus.hold         = (state != RUN);
    bus.setting      = state;
    bus.disp_hours   = bus.cur_hours;
    bus.disp_minutes = bus.cur_minutes;
    bus.blink        = 1'b1;
    if (state != RUN) begin
      bus.disp_hours   = edit_h;
      bus.disp_minutes = edit_m;
      bus.blink        = blink_q;
    end
  end

  assign bus.load         = load_q;
  assign bus.load_hours   = load_hours_q;
  assign bus.load_minutes = load_minutes_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: button sequences with hand-computed results.
module tb_time_set_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;

  int checks = 0;
  int failures = 0;

  int         load_count = 0;
  logic [4:0] seen_lh = '0;
  logic [5:0] seen_lm = '0;
  logic       hold_at_load = 1'b1;
  logic       hold_before_load = 1'b0;
  logic       hold_last = 1'b0;

  time_set_ctrl_if bus();

  time_set_ctrl #(
    .DEBOUNCE_TICKS(5),
    .REPEAT_DELAY(50),
    .REPEAT_RATE(10),
    .BLINK_HALF(25)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .bus(bus)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Record every load strobe and the hold level around it
  always @(negedge clk) begin
    if (bus.load) begin
      load_count++;
      seen_lh          = bus.load_hours;
      seen_lm          = bus.load_minutes;
      hold_at_load     = bus.hold;
      hold_before_load = hold_last;
    end
    hold_last = bus.hold;
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive the raw buttons for a number of cycles
  task automatic applyStimulus(input logic mode, input logic inc, input int cycles);
    btn_mode = mode;
    btn_inc  = inc;
    repeat (cycles) @(negedge clk);
  endtask

  // One clean press: long enough to debounce, then released and settled
  task automatic pressButtons(input logic mode, input logic inc);
    applyStimulus(mode, inc, 10);
    applyStimulus(1'b0, 1'b0, 10);
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.cur_hours   = 5'd13;
    bus.cur_minutes = 6'd45;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_setting", bus.setting, 0);
    checkOutput("rst_hold", bus.hold, 0);
    checkOutput("rst_load", bus.load, 0);
    checkOutput("rst_blink", bus.blink, 1);
    checkOutput("rst_load_hours", bus.load_hours, 0);
    checkOutput("rst_load_minutes", bus.load_minutes, 0);
    checkOutput("rst_disp_hours", bus.disp_hours, 13);
    checkOutput("rst_disp_minutes", bus.disp_minutes, 45);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Short glitch on MODE is filtered
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("glitch_setting", bus.setting, 0);
    checkOutput("glitch_load_count", load_count, 0);

    // 13:45 -> 15:46 edit sequence
    pressButtons(1'b1, 1'b0);
    checkOutput("seq_enter_set_h", bus.setting, 1);
    checkOutput("seq_hold_set_h", bus.hold, 1);
    checkOutput("seq_capture_h", bus.disp_hours, 13);
    checkOutput("seq_capture_m", bus.disp_minutes, 45);
    pressButtons(1'b0, 1'b1);
    pressButtons(1'b0, 1'b1);
    checkOutput("seq_edit_h", bus.disp_hours, 15);
    pressButtons(1'b1, 1'b0);
    checkOutput("seq_enter_set_m", bus.setting, 2);
    checkOutput("seq_hold_set_m", bus.hold, 1);
    pressButtons(1'b0, 1'b1);
    checkOutput("seq_edit_m", bus.disp_minutes, 46);
    checkOutput("seq_edit_h_kept", bus.disp_hours, 15);
    pressButtons(1'b1, 1'b0);
    checkOutput("seq_load_count", load_count, 1);
    checkOutput("seq_load_hours", seen_lh, 15);
    checkOutput("seq_load_minutes", seen_lm, 46);
    checkOutput("seq_hold_at_load", hold_at_load, 0);
    checkOutput("seq_hold_before_load", hold_before_load, 1);
    checkOutput("seq_back_to_run", bus.setting, 0);
    checkOutput("seq_run_disp", bus.disp_hours, 13);
    checkOutput("seq_load_held", bus.load_hours, 15);

    // Wrap boundaries plus blink timing on entry
    bus.cur_hours   = 5'd22;
    bus.cur_minutes = 6'd58;
    btn_mode = 1'b1;
    n = 0;
    while (bus.setting != 2'd1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    btn_mode = 1'b0;
    checkOutput("wrap_enter_set_h", bus.setting, 1);
    checkOutput("blink_entry", bus.blink, 1);
    repeat (24) @(negedge clk);
    checkOutput("blink_last_high", bus.blink, 1);
    @(negedge clk);
    checkOutput("blink_first_low", bus.blink, 0);
    repeat (25) @(negedge clk);
    checkOutput("blink_high_again", bus.blink, 1);
    pressButtons(1'b0, 1'b1);
    checkOutput("wrap_h_23", bus.disp_hours, 23);
    pressButtons(1'b0, 1'b1);
    checkOutput("wrap_h_0", bus.disp_hours, 0);
    pressButtons(1'b0, 1'b1);
    checkOutput("wrap_h_1", bus.disp_hours, 1);
    pressButtons(1'b1, 1'b0);
    checkOutput("wrap_set_m_start", bus.disp_minutes, 58);
    checkOutput("blink_set_m_entry", bus.blink, 1);
    pressButtons(1'b0, 1'b1);
    checkOutput("wrap_m_59", bus.disp_minutes, 59);
    pressButtons(1'b0, 1'b1);
    checkOutput("wrap_m_0", bus.disp_minutes, 0);
    pressButtons(1'b1, 1'b0);
    checkOutput("wrap_load_count", load_count, 2);
    checkOutput("wrap_load_hours", seen_lh, 1);
    checkOutput("wrap_load_minutes", seen_lm, 0);
    checkOutput("wrap_run_blink", bus.blink, 1);

    // Held INC: press plus three repeats, nothing after release
    bus.cur_hours   = 5'd10;
    bus.cur_minutes = 6'd20;
    pressButtons(1'b1, 1'b0);
    pressButtons(1'b1, 1'b0);
    checkOutput("rep_in_set_m", bus.setting, 2);
    checkOutput("rep_start", bus.disp_minutes, 20);
    applyStimulus(1'b0, 1'b1, 75);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("rep_four_incs", bus.disp_minutes, 24);
    repeat (100) @(negedge clk);
    checkOutput("rep_stopped", bus.disp_minutes, 24);
    pressButtons(1'b1, 1'b0);
    checkOutput("rep_load_count", load_count, 3);
    checkOutput("rep_load_hours", seen_lh, 10);
    checkOutput("rep_load_minutes", seen_lm, 24);

    // Coincident MODE and INC in SET_H: MODE wins
    bus.cur_hours   = 5'd7;
    bus.cur_minutes = 6'd30;
    pressButtons(1'b1, 1'b0);
    checkOutput("both_pre_set_h", bus.setting, 1);
    pressButtons(1'b1, 1'b1);
    checkOutput("both_setting", bus.setting, 2);
    checkOutput("both_edit_h", bus.disp_hours, 7);

    // Reset mid-SET_M discards the edit
    pressButtons(1'b0, 1'b1);
    checkOutput("rstmid_edit_m", bus.disp_minutes, 31);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_setting", bus.setting, 0);
    checkOutput("rstmid_hold", bus.hold, 0);
    checkOutput("rstmid_load", bus.load, 0);
    checkOutput("rstmid_blink", bus.blink, 1);
    checkOutput("rstmid_disp_minutes", bus.disp_minutes, 30);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("rstmid_no_load", load_count, 3);
    checkOutput("rstmid_stays_run", bus.setting, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
